// File: rtl/exp_ascii_to_biased_if.sv
// Handshake bundle for the serial ASCII exponent parser: character input and result output.
interface exp_ascii_to_biased_if;
    logic       in_valid;
    logic [7:0] in_char;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_exp;
    logic       out_err;

    modport master (
        output in_valid, in_char, in_last, out_ready,
        input  in_ready, out_valid, out_exp, out_err
    );

    modport slave (
        input  in_valid, in_char, in_last, out_ready,
        output in_ready, out_valid, out_exp, out_err
    );
endinterface

// File: rtl/exp_ascii_to_biased.sv
// Serial ASCII signed decimal exponent -> IEEE-754 single biased exponent.
module exp_ascii_to_biased #(
    parameter int unsigned BIAS       = 127,
    parameter int unsigned MAX_DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    exp_ascii_to_biased_if.slave  bus
);

    localparam int unsigned MAG_W = 10;
    localparam int unsigned CNT_W = 2;
    localparam int unsigned RES_W = 11;
    localparam int unsigned EXP_W = 8;

    typedef enum logic [1:0] {
        S_SIGN = 2'd0,
        S_DIG  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                 state, state_n;
    logic                   neg, neg_n;
    logic [MAG_W-1:0]       mag, mag_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic                   err, err_n;
    logic                   out_valid_r, out_valid_n;
    logic [EXP_W-1:0]       out_exp_r, out_exp_n;
    logic                   out_err_r, out_err_n;

    logic                   accept;
    logic                   is_digit;
    logic                   is_plus;
    logic                   is_minus;
    logic [MAG_W-1:0]       dval;
    logic signed [RES_W-1:0] res;
    logic                   res_bad;

    // Character intake is blocked while a result is pending and during reset.
    assign bus.in_ready  = (state != S_OUT) && !rst;
    assign accept        = bus.in_valid && bus.in_ready;
    assign is_digit      = (bus.in_char >= 8'h30) && (bus.in_char <= 8'h39);
    assign is_plus       = (bus.in_char == 8'h2B);
    assign is_minus      = (bus.in_char == 8'h2D);
    assign dval          = MAG_W'(bus.in_char[3:0]);

    assign bus.out_valid = out_valid_r;
    assign bus.out_exp   = out_exp_r;
    assign bus.out_err   = out_err_r;

    // Next-state, digit accumulation and result formation.
    always_comb begin
        state_n     = state;
        neg_n       = neg;
        mag_n       = mag;
        cnt_n       = cnt;
        err_n       = err;
        out_valid_n = out_valid_r;
        out_exp_n   = out_exp_r;
        out_err_n   = out_err_r;
        res         = '0;
        res_bad     = 1'b0;

        case (state)
            S_SIGN: begin
                if (accept) begin
                    state_n = S_DIG;
                    if (is_plus) begin
                        neg_n = 1'b0;
                    end else if (is_minus) begin
                        neg_n = 1'b1;
                    end else if (is_digit) begin
                        neg_n = 1'b0;
                        mag_n = dval;
                        cnt_n = CNT_W'(1);
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_DIG: begin
                // After an error the rest of the exponent is drained without effect.
                if (accept && !err) begin
                    if (is_digit && (cnt < CNT_W'(MAX_DIGITS))) begin
                        mag_n = (mag << 3) + (mag << 1) + dval;
                        cnt_n = cnt + CNT_W'(1);
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_n     = S_SIGN;
                    neg_n       = 1'b0;
                    mag_n       = '0;
                    cnt_n       = '0;
                    err_n       = 1'b0;
                    out_valid_n = 1'b0;
                end
            end
            default: begin
                state_n = S_SIGN;
            end
        endcase

        // The final character is parsed above, then the result is formed from the updated value.
        if (accept && bus.in_last) begin
            res         = neg_n ? (RES_W'(BIAS) - RES_W'(mag_n)) : (RES_W'(BIAS) + RES_W'(mag_n));
            res_bad     = (cnt_n == '0) || (res < $signed(RES_W'(1))) || (res > $signed(RES_W'(254)));
            err_n       = err_n || res_bad;
            state_n     = S_OUT;
            out_valid_n = 1'b1;
            out_err_n   = err_n || res_bad;
            out_exp_n   = (err_n || res_bad) ? '0 : res[EXP_W-1:0];
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_SIGN;
            neg         <= 1'b0;
            mag         <= '0;
            cnt         <= '0;
            err         <= 1'b0;
            out_valid_r <= 1'b0;
            out_exp_r   <= '0;
            out_err_r   <= 1'b0;
        end else begin
            state       <= state_n;
            neg         <= neg_n;
            mag         <= mag_n;
            cnt         <= cnt_n;
            err         <= err_n;
            out_valid_r <= out_valid_n;
            out_exp_r   <= out_exp_n;
            out_err_r   <= out_err_n;
        end
    end

endmodule
